// File: rtl/neuron_step_controller_if.sv
// Control handshake between the step controller, the neuron core and the
// spike-event consumer (NoC packetiser).
//   master: the step controller
//   slave : the core and the event consumer
interface neuron_step_controller_if #(
  parameter int ID_W = 4
) ();

  // core control
  logic [ID_W-1:0] core_sel;
  logic            core_start_update;
  logic            core_start_reset;
  logic            core_busy;
  logic            core_spike;

  // spike event stream
  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_ready;

  modport master (
    output core_sel,
    output core_start_update,
    output core_start_reset,
    input  core_busy,
    input  core_spike,
    output evt_valid,
    output evt_id,
    input  evt_ready
  );

  modport slave (
    input  core_sel,
    input  core_start_update,
    input  core_start_reset,
    output core_busy,
    output core_spike,
    input  evt_valid,
    input  evt_id,
    output evt_ready
  );

endinterface

// File: rtl/neuron_step_controller.sv
// Time-step controller for the neuron core.
//
// Each time step walks every neuron index in order:
//   1. issue an update to the core
//   2. if the update spikes, queue the index as a spike event
//   3. then issue a reset to the core
// Spike events are buffered in a small FIFO that feeds the NoC packetiser.
// The FIFO is not cleared between steps, so the consumer may keep draining it
// while the next step runs.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for step_start
// UPD_REQ  | core_start_update pulse for the current index
// UPD_ACK  | waiting for the core to raise busy after the update request
// UPD_WAIT | update running; decide on spike when busy falls
// PUSH     | queue the spiking index; stalls while the FIFO is full
// RST_REQ  | core_start_reset pulse for the current index
// RST_ACK  | waiting for the core to raise busy after the reset request
// RST_WAIT | reset running; leave when busy falls
// NEXT     | advance the index, or finish after the last neuron
// DONE     | step_done pulse, then back to IDLE
module neuron_step_controller #(
  parameter int NUM_NEURONS = 16,
  parameter int ID_W        = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    step_start,
  output logic                    step_busy,
  output logic                    step_done,
  output logic [ID_W:0]           step_spike_count,
  neuron_step_controller_if.master bus
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_NEURONS - 1);
  localparam logic [ID_W:0]   MAX_COUNT = (ID_W + 1)'(NUM_NEURONS);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] UPD_REQ  = 4'd1;
  localparam logic [3:0] UPD_ACK  = 4'd2;
  localparam logic [3:0] UPD_WAIT = 4'd3;
  localparam logic [3:0] PUSH     = 4'd4;
  localparam logic [3:0] RST_REQ  = 4'd5;
  localparam logic [3:0] RST_ACK  = 4'd6;
  localparam logic [3:0] RST_WAIT = 4'd7;
  localparam logic [3:0] NEXT     = 4'd8;
  localparam logic [3:0] DONE     = 4'd9;

  logic [3:0]      state;
  logic [ID_W-1:0] index;

  logic [ID_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            fifo_empty;
  logic            fifo_full;
  logic            do_push;
  logic            do_pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  // the push; the slot being written is the one being read out this cycle.
  assign do_pop  = !fifo_empty && bus.evt_ready;
  assign do_push = (state == PUSH) && (!fifo_full || do_pop);

  // Step sequencing: walk the indices, handshake with the core, count spikes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      index            <= '0;
      step_busy        <= 1'b0;
      step_spike_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (step_start) begin
            index            <= '0;
            step_spike_count <= '0;
            step_busy        <= 1'b1;
            state            <= UPD_REQ;
          end
        end
        UPD_REQ: begin
          state <= UPD_ACK;
        end
        UPD_ACK: begin
          if (bus.core_busy) begin
            state <= UPD_WAIT;
          end
        end
        UPD_WAIT: begin
          if (!bus.core_busy) begin
            state <= bus.core_spike ? PUSH : NEXT;
          end
        end
        PUSH: begin
          if (do_push) begin
            if (step_spike_count != MAX_COUNT) begin
              step_spike_count <= step_spike_count + 1'b1;
            end
            state <= RST_REQ;
          end
        end
        RST_REQ: begin
          state <= RST_ACK;
        end
        RST_ACK: begin
          if (bus.core_busy) begin
            state <= RST_WAIT;
          end
        end
        RST_WAIT: begin
          if (!bus.core_busy) begin
            state <= NEXT;
          end
        end
        NEXT: begin
          if (index == LAST_IDX) begin
            state <= DONE;
          end else begin
            index <= index + 1'b1;
            state <= UPD_REQ;
          end
        end
        DONE: begin
          step_busy <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Spike event FIFO: storage and wrap-bit pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        fifo_mem[wr_ptr[AW-1:0]] <= index;
        wr_ptr                   <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // The core only ever sees the index held in the register, which moves in
  // NEXT while the core is idle.
  assign bus.core_sel          = index;
  assign bus.core_start_update = (state == UPD_REQ);
  assign bus.core_start_reset  = (state == RST_REQ);
  assign step_done             = (state == DONE);

  // Head data comes straight from the storage flops.
  assign bus.evt_valid = !fifo_empty;
  assign bus.evt_id    = fifo_mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_neuron_step_controller.sv
// Directed bench for neuron_step_controller with a behavioural core model.
module tb_neuron_step_controller;

  localparam int UPD_L = 12;

  logic clk;
  logic rst;
  logic step_start;
  logic step_busy;
  logic step_done;
  logic [4:0] step_spike_count;

  neuron_step_controller_if #(.ID_W(4)) bus ();

  neuron_step_controller #(
    .NUM_NEURONS(16),
    .ID_W(4),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .step_start(step_start),
    .step_busy(step_busy),
    .step_done(step_done),
    .step_spike_count(step_spike_count),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // core model: busy follows a request after (1 + busy_delay) cycles,
  // UPD_L busy cycles for an update, 2 for a reset
  int          busy_delay = 0;
  logic [15:0] spike_mask = 16'h0000;
  int          wait_cnt;
  int          run_cnt;
  logic        spike_r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 0;
      run_cnt  <= 0;
      spike_r  <= 1'b0;
    end else if (bus.core_start_update) begin
      wait_cnt <= busy_delay;
      run_cnt  <= UPD_L;
      spike_r  <= spike_mask[bus.core_sel];
    end else if (bus.core_start_reset) begin
      wait_cnt <= 0;
      run_cnt  <= 2;
    end else if (wait_cnt > 0) begin
      wait_cnt <= wait_cnt - 1;
    end else if (run_cnt > 0) begin
      run_cnt <= run_cnt - 1;
    end
  end

  assign bus.core_busy  = (wait_cnt == 0) && (run_cnt != 0);
  assign bus.core_spike = spike_r;

  // monitor: pulse logs and handshake rule violations
  int         upd_cnt  = 0;
  int         rst_cnt  = 0;
  int         done_cnt = 0;
  int         viol     = 0;
  logic [3:0] sel_log [256];
  logic [3:0] rst_log [256];

  always @(negedge clk) begin
    if (bus.core_start_update) begin
      if (upd_cnt < 256) sel_log[upd_cnt] <= bus.core_sel;
      upd_cnt <= upd_cnt + 1;
    end
    if (bus.core_start_reset) begin
      if (rst_cnt < 256) rst_log[rst_cnt] <= bus.core_sel;
      rst_cnt <= rst_cnt + 1;
    end
    if (step_done) done_cnt <= done_cnt + 1;
    if ((bus.core_start_update && bus.core_start_reset) ||
        ((bus.core_start_update || bus.core_start_reset) && bus.core_busy))
      viol <= viol + 1;
  end

  int total = 0;
  int bad   = 0;
  int k     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(negedge clk);
      k++;
    end
  endtask

  // one-cycle step_start; k = 0 at the first negedge after the accept edge
  task automatic start_step();
    @(negedge clk);
    step_start = 1'b1;
    @(negedge clk);
    step_start = 1'b0;
    k = 0;
  endtask

  task automatic wait_done(input int budget);
    while (!step_done && k < budget) adv(1);
    chk("done_seen", {31'd0, step_done}, 32'd1);
  endtask

  int         ub, rb, db;
  int         n, dseen, guard;
  logic [3:0] got [16];

  initial begin
    rst            = 1'b1;
    step_start     = 1'b0;
    bus.evt_ready  = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_busy",      {31'd0, step_busy}, 0);
    chk("rst_done",      {31'd0, step_done}, 0);
    chk("rst_count",     {27'd0, step_spike_count}, 0);
    chk("rst_sel",       {28'd0, bus.core_sel}, 0);
    chk("rst_upd",       {31'd0, bus.core_start_update}, 0);
    chk("rst_rstp",      {31'd0, bus.core_start_reset}, 0);
    chk("rst_evt_valid", {31'd0, bus.evt_valid}, 0);
    chk("rst_evt_id",    {28'd0, bus.evt_id}, 0);
    rst = 1'b0;
    adv(2);

    // 1: no spikes, 16 neurons x 15 cycles
    ub = upd_cnt; rb = rst_cnt; db = done_cnt;
    start_step();
    chk("t1_busy_after_start", {31'd0, step_busy}, 1);
    wait_done(400);
    chk("t1_cycles", k, 240);
    chk("t1_count", {27'd0, step_spike_count}, 0);
    adv(1);
    chk("t1_busy_after_done", {31'd0, step_busy}, 0);
    adv(2);
    chk("t1_upd_pulses", upd_cnt - ub, 16);
    chk("t1_rst_pulses", rst_cnt - rb, 0);
    chk("t1_done_pulses", done_cnt - db, 1);
    chk("t1_evt_valid", {31'd0, bus.evt_valid}, 0);
    for (int i = 0; i < 16; i++) chk("t1_sel_order", {28'd0, sel_log[ub + i]}, i);

    // 2: spikes on 3 and 9
    spike_mask = 16'h0208;
    ub = upd_cnt; rb = rst_cnt;
    start_step();
    wait_done(400);
    chk("t2_cycles", k, 250);
    chk("t2_count", {27'd0, step_spike_count}, 2);
    adv(3);
    chk("t2_rst_pulses", rst_cnt - rb, 2);
    chk("t2_rst_first", {28'd0, rst_log[rb]}, 3);
    chk("t2_rst_second", {28'd0, rst_log[rb + 1]}, 9);
    chk("t2_evt_valid", {31'd0, bus.evt_valid}, 1);
    chk("t2_evt_id0", {28'd0, bus.evt_id}, 3);
    bus.evt_ready = 1'b1;
    adv(1);
    bus.evt_ready = 1'b0;
    chk("t2_evt_id1", {28'd0, bus.evt_id}, 9);
    bus.evt_ready = 1'b1;
    adv(1);
    chk("t2_empty", {31'd0, bus.evt_valid}, 0);
    adv(2);
    chk("t2_pop_empty", {31'd0, bus.evt_valid}, 0);
    bus.evt_ready = 1'b0;
    adv(1);

    // 3: every neuron spikes, consumer stalled -> PUSH stall at neuron 8
    spike_mask = 16'hFFFF;
    rb = rst_cnt; db = done_cnt;
    start_step();
    adv(200);
    chk("t3_stall_busy", {31'd0, step_busy}, 1);
    chk("t3_stall_sel", {28'd0, bus.core_sel}, 8);
    chk("t3_stall_count", {27'd0, step_spike_count}, 8);
    chk("t3_stall_rst_pulses", rst_cnt - rb, 8);
    chk("t3_stall_done", done_cnt - db, 0);
    chk("t3_stall_head", {28'd0, bus.evt_id}, 0);
    bus.evt_ready = 1'b1;
    n = 0; dseen = 0; guard = 0;
    while ((n < 16 || dseen == 0) && guard < 600) begin
      if (step_done) dseen++;
      if (bus.evt_valid && n < 16) begin
        got[n] = bus.evt_id;
        n++;
      end
      @(negedge clk);
      guard++;
    end
    bus.evt_ready = 1'b0;
    chk("t3_popped", n, 16);
    chk("t3_done_seen", dseen, 1);
    for (int i = 0; i < 16; i++) chk("t3_evt_order", {28'd0, got[i]}, i);
    chk("t3_count", {27'd0, step_spike_count}, 16);
    adv(3);
    chk("t3_empty", {31'd0, bus.evt_valid}, 0);
    chk("t3_idle", {31'd0, step_busy}, 0);

    // 4: step_start while busy is ignored
    spike_mask = 16'h0004;
    db = done_cnt;
    start_step();
    adv(100);
    step_start = 1'b1;
    adv(3);
    step_start = 1'b0;
    chk("t4_busy", {31'd0, step_busy}, 1);
    chk("t4_count_kept", {27'd0, step_spike_count}, 1);
    chk("t4_sel", {28'd0, bus.core_sel}, 6);
    wait_done(400);
    chk("t4_cycles", k, 245);
    adv(20);
    chk("t4_done_pulses", done_cnt - db, 1);
    chk("t4_count_held", {27'd0, step_spike_count}, 1);

    // 5: rst in UPD_WAIT of neuron 5
    spike_mask = 16'h0000;
    start_step();
    adv(80);
    chk("t5_pre_sel", {28'd0, bus.core_sel}, 5);
    chk("t5_pre_evt_valid", {31'd0, bus.evt_valid}, 1);
    chk("t5_pre_evt_id", {28'd0, bus.evt_id}, 2);
    db = done_cnt;
    rst = 1'b1;
    #1;
    chk("t5_busy", {31'd0, step_busy}, 0);
    chk("t5_done", {31'd0, step_done}, 0);
    chk("t5_count", {27'd0, step_spike_count}, 0);
    chk("t5_sel", {28'd0, bus.core_sel}, 0);
    chk("t5_upd", {31'd0, bus.core_start_update}, 0);
    chk("t5_rstp", {31'd0, bus.core_start_reset}, 0);
    chk("t5_evt_valid", {31'd0, bus.evt_valid}, 0);
    chk("t5_evt_id", {28'd0, bus.evt_id}, 0);
    @(negedge clk);
    rst = 1'b0;
    adv(20);
    chk("t5_no_done", done_cnt - db, 0);
    chk("t5_idle", {31'd0, step_busy}, 0);
    start_step();
    chk("t5_restart_sel", {28'd0, bus.core_sel}, 0);
    chk("t5_restart_upd", {31'd0, bus.core_start_update}, 1);
    wait_done(400);
    chk("t5_cycles", k, 240);
    adv(3);

    // 6: core busy rises 3 cycles late
    busy_delay = 3;
    ub = upd_cnt;
    start_step();
    wait_done(500);
    chk("t6_cycles", k, 288);
    adv(3);
    chk("t6_upd_pulses", upd_cnt - ub, 16);
    chk("t6_count", {27'd0, step_spike_count}, 0);
    busy_delay = 0;

    chk("handshake_rules", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
